// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for a 5-stage F/D/E/M/W pipeline: operand forwarding selects,
// load-use stalls and taken-branch flushes. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_unit #(
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned PC_REG     = 15,
   parameter int unsigned PERF_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid,
   input  logic [REG_ADDR_W-1:0] dec_src1,
   input  logic [REG_ADDR_W-1:0] dec_src2,
   input  logic [REG_ADDR_W-1:0] dec_src3,
   input  logic                  dec_use1,
   input  logic                  dec_use2,
   input  logic                  dec_use3,
   input  logic [REG_ADDR_W-1:0] dec_wreg,
   input  logic                  dec_reg_write,
   input  logic                  dec_mem_to_reg,
   input  logic                  ex_branch_taken,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic [1:0]            fwd_c
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] stall_count,
   output logic [PERF_CNT_W-1:0] flush_count
`endif
);

   localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_M  = 2'b01;
   localparam logic [1:0] FWD_W  = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] wreg;
      logic                  reg_write;
      logic                  mem_to_reg;
   } stage_t;

   stage_t                     e_q, m_q, w_q, e_d;
   logic [2:0][REG_ADDR_W-1:0] e_src_q, e_src_d, dec_src;
   logic [2:0]                 e_use_q, e_use_d, dec_use;
   logic [2:0][1:0]            fwd;
   logic                       lu, br;

   // M/W load flags are tracked for completeness but nothing downstream needs them
   logic unused_stage_bits;
   assign unused_stage_bits = m_q.mem_to_reg ^ w_q.mem_to_reg;

   assign dec_src = {dec_src3, dec_src2, dec_src1};
   assign dec_use = {dec_use3, dec_use2, dec_use1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q     <= '0;
         m_q     <= '0;
         w_q     <= '0;
         e_src_q <= '0;
         e_use_q <= '0;
      end else begin
         e_q     <= e_d;
         m_q     <= e_q;
         w_q     <= m_q;
         e_src_q <= e_src_d;
         e_use_q <= e_use_d;
      end
   end

   always_comb begin
      fwd = '0;
      lu  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (e_q.valid && e_use_q[i] && (e_src_q[i] != PC_ADDR)) begin
            if (m_q.valid && m_q.reg_write && (m_q.wreg == e_src_q[i]))
               fwd[i] = FWD_M;
            else if (w_q.valid && w_q.reg_write && (w_q.wreg == e_src_q[i]))
               fwd[i] = FWD_W;
            else
               fwd[i] = FWD_RF;
         end
         if (dec_use[i] && (dec_src[i] == e_q.wreg) && (dec_src[i] != PC_ADDR))
            lu = 1'b1;
      end
      lu = lu & e_q.valid & e_q.mem_to_reg & e_q.reg_write & dec_valid;
      br = ex_branch_taken & e_q.valid;

      // A taken branch discards the decode instruction, so any load-use stall is moot
      stall_f = lu & ~br;
      stall_d = lu & ~br;
      flush_d = br;
      flush_e = lu | br;
      fwd_a   = fwd[0];
      fwd_b   = fwd[1];
      fwd_c   = fwd[2];

      e_d.valid      = dec_valid & ~flush_e;
      e_d.wreg       = dec_wreg;
      e_d.reg_write  = dec_reg_write;
      e_d.mem_to_reg = dec_mem_to_reg;
      e_src_d        = dec_src;
      e_use_d        = dec_use;
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Saturating counters: hold at all-ones instead of wrapping
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
      if (flush_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + PERF_CNT_W'(1);
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`else
   localparam int unsigned unused_perf_cnt_w = PERF_CNT_W;
`endif

endmodule
